// File: rtl/eq_coef_spi_if.sv
// SPI pin bundle between the host MCU (master) and the coefficient slave.
interface eq_coef_spi_if;
    logic sck;
    logic sdi;
    logic ce;
    logic sdo;

    modport master (output sck, output sdi, output ce, input sdo);
    modport slave  (input sck, input sdi, input ce, output sdo);
endinterface

// File: rtl/eq_coef_spi.sv
// Oversampled SPI slave loading a double-buffered equalizer coefficient bank;
// a frame commits only when exactly NBANDS*COEF_W bits arrived.
//
// state     | meaning
// ST_IDLE   | ce low, sck/sdi ignored, sdo driven 0
// ST_ACTIVE | ce high, shifting sdi into shadow and readback out on sdo
module eq_coef_spi #(
    parameter int NBANDS = 4,
    parameter int COEF_W = 8,
    localparam int FRAME_BITS = NBANDS * COEF_W
) (
    input  logic                  clk,
    input  logic                  nreset,
    eq_coef_spi_if.slave          spi,
    output logic [FRAME_BITS-1:0] coefs,
    output logic                  update,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t                state_q;
    logic [2:0]            sck_q;
    logic [2:0]            ce_q;
    logic [1:0]            sdi_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shadow_q;
    logic [FRAME_BITS-1:0] rb_q;
    logic [FRAME_BITS-1:0] coefs_q;
    logic                  update_q;
    logic                  err_q;

    logic sck_rise, sck_fall, ce_rise, ce_fall;

    // bit [1] is the synchronized level, bit [2] its previous value
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign ce_rise  = ce_q[1] & ~ce_q[2];
    assign ce_fall  = ~ce_q[1] & ce_q[2];

    // Saturating at FRAME_BITS+1 keeps long frames distinguishable from exact ones.
    assign cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            sck_q    <= '0;
            ce_q     <= '0;
            sdi_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            rb_q     <= '0;
            coefs_q  <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sck_q    <= {sck_q[1:0], spi.sck};
            ce_q     <= {ce_q[1:0], spi.ce};
            sdi_q    <= {sdi_q[0], spi.sdi};
            update_q <= 1'b0;
            // ce edges win over a coincident sck edge, which is dropped
            if (ce_rise) begin
                state_q <= ST_ACTIVE;
                cnt_q   <= '0;
                rb_q    <= coefs_q;
            end else if (ce_fall) begin
                state_q <= ST_IDLE;
                if (cnt_q == CNT_FULL) begin
                    coefs_q  <= shadow_q;
                    update_q <= 1'b1;
                    err_q    <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (state_q == ST_ACTIVE) begin
                if (sck_rise) begin
                    shadow_q <= {shadow_q[FRAME_BITS-2:0], sdi_q[1]};
                    cnt_q    <= cnt_d;
                end else if (sck_fall) begin
                    rb_q <= {rb_q[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign spi.sdo   = (state_q == ST_ACTIVE) & rb_q[FRAME_BITS-1];
    assign coefs     = coefs_q;
    assign update    = update_q;
    assign frame_err = err_q;
    assign busy      = (state_q == ST_ACTIVE);
endmodule

// File: tb/tb_eq_coef_spi.sv
// Directed bench for eq_coef_spi: default 4x8 instance plus a 16x24 instance,
// with a scoreboard of expected commit results per frame.
module tb_eq_coef_spi;
    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    eq_coef_spi_if spi0 ();
    eq_coef_spi_if spi1 ();

    logic [31:0]  coefs0;
    logic [383:0] coefs1;
    logic update0, frame_err0, busy0;
    logic update1, frame_err1, busy1;

    eq_coef_spi #(.NBANDS(4), .COEF_W(8)) dut0 (
        .clk(clk), .nreset(nreset), .spi(spi0.slave),
        .coefs(coefs0), .update(update0), .frame_err(frame_err0), .busy(busy0)
    );

    eq_coef_spi #(.NBANDS(16), .COEF_W(24)) dut1 (
        .clk(clk), .nreset(nreset), .spi(spi1.slave),
        .coefs(coefs1), .update(update1), .frame_err(frame_err1), .busy(busy1)
    );

    typedef struct {
        logic [383:0] coefs;
        logic         err;
        int           upd;
        logic [383:0] rb;
        bit           chk_rb;
    } exp_t;

    exp_t         sb[$];
    logic [383:0] model0, model1;
    int errors = 0;
    int checks = 0;
    int upd0 = 0;
    int upd1 = 0;

    always @(negedge clk) begin
        if (update0 === 1'b1) upd0++;
        if (update1 === 1'b1) upd1++;
    end

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sck(input bit sel, input logic v);
        if (sel) spi1.sck = v; else spi0.sck = v;
    endtask

    task automatic set_sdi(input bit sel, input logic v);
        if (sel) spi1.sdi = v; else spi0.sdi = v;
    endtask

    task automatic set_ce(input bit sel, input logic v);
        if (sel) spi1.ce = v; else spi0.ce = v;
    endtask

    function automatic logic get_sdo(input bit sel);
        return sel ? spi1.sdo : spi0.sdo;
    endfunction

    task automatic frame(input bit sel, input logic [383:0] data, input int nbits, input int h);
        exp_t e;
        int fb;
        int u_start;
        logic [383:0] rbk;
        fb = sel ? 384 : 32;
        e.rb = sel ? model1 : model0;
        e.chk_rb = (nbits == fb);
        if (nbits == fb) begin
            if (sel) model1 = data;
            else     model0 = {352'b0, data[31:0]};
            e.err = 1'b0;
            e.upd = 1;
        end else begin
            e.err = 1'b1;
            e.upd = 0;
        end
        e.coefs = sel ? model1 : model0;
        sb.push_back(e);
        u_start = sel ? upd1 : upd0;

        set_ce(sel, 1'b1);
        wait_clk(4);
        rbk = '0;
        for (int i = 0; i < nbits; i++) begin
            set_sdi(sel, data[nbits-1-i]);
            wait_clk(h);
            rbk = {rbk[382:0], get_sdo(sel)};
            set_sck(sel, 1'b1);
            wait_clk(h);
            set_sck(sel, 1'b0);
        end
        wait_clk(4);
        set_ce(sel, 1'b0);
        set_sdi(sel, 1'b0);
        wait_clk(8);

        e = sb.pop_front();
        check(sel ? "coefs_w" : "coefs", sel ? coefs1 : {352'b0, coefs0}, e.coefs);
        check(sel ? "frame_err_w" : "frame_err", {383'b0, sel ? frame_err1 : frame_err0}, {383'b0, e.err});
        check(sel ? "update_cycles_w" : "update_cycles",
              384'((sel ? upd1 : upd0) - u_start), 384'(e.upd));
        if (e.chk_rb) check(sel ? "readback_w" : "readback", rbk, e.rb);
    endtask

    initial begin
        logic [383:0] rnd;
        int u_keep;
        nreset = 1'b0;
        spi0.sck = 1'b0; spi0.sdi = 1'b0; spi0.ce = 1'b0;
        spi1.sck = 1'b0; spi1.sdi = 1'b0; spi1.ce = 1'b0;
        model0 = '0;
        model1 = '0;
        wait_clk(3);
        check("rst_coefs", {352'b0, coefs0}, '0);
        check("rst_update", {383'b0, update0}, '0);
        check("rst_frame_err", {383'b0, frame_err0}, '0);
        check("rst_busy", {383'b0, busy0}, '0);
        check("rst_sdo", {383'b0, spi0.sdo}, '0);
        check("rst_coefs_w", coefs1, '0);
        nreset = 1'b1;
        wait_clk(3);

        frame(1'b0, 384'h12345678, 32, 5);
        frame(1'b0, 384'hA5A5A5A5, 32, 5);

        frame(1'b0, 384'h2BADF00D, 31, 5);
        frame(1'b0, 384'h1_3C3C3C3C, 33, 5);
        frame(1'b0, 384'h0F1E2D3C, 32, 5);
        frame(1'b0, '0, 0, 5);

        // reset in the middle of a frame: half of DEADBEEF shifted in
        set_ce(1'b0, 1'b1);
        wait_clk(4);
        for (int i = 0; i < 16; i++) begin
            set_sdi(1'b0, 1'(32'hDEADBEEF >> (31 - i)));
            wait_clk(5);
            set_sck(1'b0, 1'b1);
            wait_clk(5);
            set_sck(1'b0, 1'b0);
        end
        wait_clk(2);
        nreset = 1'b0;
        #1;
        model0 = '0;
        model1 = '0;
        check("midrst_coefs", {352'b0, coefs0}, '0);
        check("midrst_busy", {383'b0, busy0}, '0);
        set_ce(1'b0, 1'b0);
        set_sdi(1'b0, 1'b0);
        u_keep = upd0;
        wait_clk(3);
        nreset = 1'b1;
        wait_clk(8);
        check("midrst_no_update", 384'(upd0 - u_keep), '0);
        check("midrst_coefs_after", {352'b0, coefs0}, '0);
        check("midrst_frame_err", {383'b0, frame_err0}, '0);
        frame(1'b0, 384'hDEADBEEF, 32, 5);

        for (int k = 0; k < 12; k++) rnd[k*32 +: 32] = $urandom;
        frame(1'b1, rnd, 384, 4);
        for (int k = 0; k < 12; k++) rnd[k*32 +: 32] = $urandom;
        frame(1'b1, rnd, 384, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/eq_coef_spi.md
# eq_coef_spi

Parametrised SPI slave that receives a frame of NBANDS equalizer coefficients from the host MCU and holds them in a double-buffered register bank for the audio datapath next to the I2S receiver. All SPI pins are oversampled in the system clock domain. A frame commits atomically only if exactly NBANDS×COEF_W bits arrived; short or long frames are rejected and flagged. The active bank is shifted back out on sdo during every transaction for host readback.

## Interface
- NBANDS, 4: number of coefficient channels (1–16)
- COEF_W, 8: bits per coefficient (4–24)
- FRAME_BITS (derived, not overridable): NBANDS×COEF_W
- clk  in  1  system clock, 12 MHz from HSOSC
- nreset  in  1  reset; one clock, reset is asynchronous and active-low
- sck  in  1  SPI clock from host (mode 0), asynchronous to clk
- sdi  in  1  SPI data in, MSB first
- ce  in  1  chip enable, active-high; frame boundary
- sdo  out  1  readback data, MSB first
- coefs  out  FRAME_BITS  active bank; band 0 in the MSBs, band NBANDS-1 in the LSBs
- update  out  1  one-clk pulse when coefs changes
- frame_err  out  1  sticky: last frame had wrong bit count
- busy  out  1  synchronized ce (transaction in progress)

## Operation
- sck, sdi and ce each pass through a 2-FF synchronizer, then a third register used for edge detection. All logic runs on clk only.
- ce rise (sync): clear bit counter; load readback shift register from coefs; busy=1.
- sck rise while busy: shadow <= {shadow[FRAME_BITS-2:0], sdi_sync}. Bit counter increments and saturates at FRAME_BITS+1. The shadow register keeps shifting past FRAME_BITS.
- sck fall while busy: readback register shifts left with 0 fill; sdo = readback MSB.
- ce fall (sync), bit count == FRAME_BITS:
  - coefs <= shadow
  - update=1 for one clk
  - frame_err <= 0
- ce fall (sync), any other count, including 0:
  - coefs unchanged, no update
  - frame_err <= 1
- ce low: sdo=0; sck and sdi are ignored.
- Simultaneous sck edge and ce rise in the same clk: ce takes priority and the sck edge is dropped.
- Simultaneous sck edge and ce fall in the same clk: the transaction ends and the edge is dropped.
- Reset values: coefs=0, update=0, frame_err=0, busy=0, sdo=0, shadow=0, counter=0.
- Reset mid-frame: partial data discarded, coefs=0, no update pulse after release.

## Timing
- Detection latency of any pin edge: 3 clk rising edges after the pad changes, ±1 clk of jitter.
- Requirements on the host:
  - sck high and low phases each ≥ 4 clk (≤ 1.5 MHz at 12 MHz clk)
  - ce setup to first sck rise ≥ 4 clk
  - ce hold after last sck fall ≥ 4 clk
- sdo is valid 3–4 clk after each sck fall. The host samples on sck rise.
- Commit: coefs and update change on the clk edge after the ce-fall detection, which is 4 clk after the pad. update is high for exactly that one clk.
- Back-to-back frames are allowed with ce low ≥ 4 clk.

## Test plan
- Reset, then NBANDS=4, COEF_W=8, sending 32'h12345678:
  - coefs == 32'h12345678
  - update high exactly 1 clk
  - frame_err=0
- Second frame sending 32'hA5A5A5A5:
  - sdo captured MSB first == 32'h12345678
  - afterwards coefs == 32'hA5A5A5A5
- 31-bit frame, then 33-bit frame:
  - coefs stays 32'hA5A5A5A5 throughout
  - no update pulse
  - frame_err=1 after each
  - a following valid 32-bit frame clears frame_err
- ce pulsed with zero sck edges: frame_err=1, coefs unchanged.
- nreset asserted after 16 bits of a frame, released, then a full frame 32'hDEADBEEF:
  - coefs=0 immediately on reset
  - coefs == 32'hDEADBEEF after the frame
- Parameter sweep NBANDS=16, COEF_W=24, with a random 384-bit frame at the maximum sck rate:
  - exact commit
  - readback matches the previously committed frame
